// File: rtl/bcd_display_mux.sv
// Two-digit BCD seven-segment multiplexer: captures on the rising edge of in_DONE and alternates
// units/tens with blanking guard phases; outputs are registered (one cycle after state). Optional LEADING_ZERO_BLANK_EN.
module bcd_display_mux #(
    parameter logic [15:0] REFRESH_DIV = 16'd50000,
    parameter logic [3:0]  GUARD_CYC   = 4'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_UND,
    input  logic [3:0] in_DEC,
    input  logic       in_DONE,
    output logic [6:0] out_SEG,
    output logic [1:0] out_AN,
    output logic       out_VALID
);

    typedef enum logic [2:0] {
        IDLE,
        GUARD_UND,
        SHOW_UND,
        GUARD_DEC,
        SHOW_DEC
    } state_t;

    localparam logic [15:0] GUARD_LD = {12'd0, GUARD_CYC} - 16'd1;
    localparam logic [15:0] SHOW_LD  = REFRESH_DIV - 16'd1;
    localparam logic [6:0]  SEG_OFF  = 7'h7F;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        done_q;
    logic [3:0]  und_q, dec_q;
    logic        valid_q;
    logic        cap;
    logic [6:0]  seg_d;
    logic [1:0]  an_d;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign cap = in_DONE & ~done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q  <= 1'b0;
            und_q   <= 4'd0;
            dec_q   <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            done_q <= in_DONE;
            if (cap) begin
                und_q   <= in_UND;
                dec_q   <= in_DEC;
                valid_q <= 1'b1;
            end
        end
    end

    // Captures never touch the phase timer; only the phase sequencer reloads it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (cap) begin
                state_d = GUARD_UND;
                cnt_d   = GUARD_LD;
            end
        end else if (cnt_q == 16'd0) begin
            case (state_q)
                GUARD_UND: begin state_d = SHOW_UND;  cnt_d = SHOW_LD;  end
                SHOW_UND:  begin state_d = GUARD_DEC; cnt_d = GUARD_LD; end
                GUARD_DEC: begin state_d = SHOW_DEC;  cnt_d = SHOW_LD;  end
                default:   begin state_d = GUARD_UND; cnt_d = GUARD_LD; end
            endcase
        end else begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        seg_d = SEG_OFF;
        an_d  = 2'b11;
        case (state_q)
            SHOW_UND: begin
                seg_d = enc(und_q);
                an_d  = 2'b10;
            end
            SHOW_DEC: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (dec_q != 4'd0) begin
                    seg_d = enc(dec_q);
                    an_d  = 2'b01;
                end
`else
                seg_d = enc(dec_q);
                an_d  = 2'b01;
`endif
            end
            default: begin
                seg_d = SEG_OFF;
                an_d  = 2'b11;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_SEG <= SEG_OFF;
            out_AN  <= 2'b11;
        end else begin
            out_SEG <= seg_d;
            out_AN  <= an_d;
        end
    end

    assign out_VALID = valid_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux with REFRESH_DIV=8, GUARD_CYC=2 (20-cycle display period).
// Expected outputs come from hand-derived pattern tables keyed on the cycle count since first capture.
module tb_bcd_display_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_UND = 4'd0;
    logic [3:0] in_DEC = 4'd0;
    logic       in_DONE = 1'b0;
    logic [6:0] out_SEG;
    logic [1:0] out_AN;
    logic       out_VALID;

    int errors = 0;
    int checks = 0;
    int k = 0;

    // Expected display content: units/tens segment codes and the tens anode pattern.
    logic [6:0] su;
    logic [6:0] sd;
    logic [1:0] dec_an;

    bcd_display_mux #(
        .REFRESH_DIV(16'd8),
        .GUARD_CYC  (4'd2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_UND   (in_UND),
        .in_DEC   (in_DEC),
        .in_DONE  (in_DONE),
        .out_SEG  (out_SEG),
        .out_AN   (out_AN),
        .out_VALID(out_VALID)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        k++;
    endtask

    // Output after posedge k (k=0 is the first capture edge): guard 2, units 8, guard 2, tens 8.
    function automatic logic [1:0] exp_an(input int kk);
        int m;
        m = (kk - 1) % 20;
        if (m < 2)       return 2'b11;
        else if (m < 10) return 2'b10;
        else if (m < 12) return 2'b11;
        else             return dec_an;
    endfunction

    function automatic logic [6:0] exp_seg(input int kk);
        int m;
        m = (kk - 1) % 20;
        if (m < 2)       return 7'h7F;
        else if (m < 10) return su;
        else if (m < 12) return 7'h7F;
        else if (dec_an == 2'b11) return 7'h7F;
        else             return sd;
    endfunction

    task automatic test_reset;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (out_SEG !== 7'h7F || out_AN !== 2'b11 || out_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: seg=%h an=%b vld=%b want 7f 11 0", out_SEG, out_AN, out_VALID);
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (out_SEG !== 7'h7F || out_AN !== 2'b11 || out_VALID !== 1'b0) begin
                errors++;
                $display("FAIL idle_%0d: seg=%h an=%b vld=%b want 7f 11 0", i, out_SEG, out_AN, out_VALID);
            end
        end
    endtask

    task automatic test_capture;
        in_UND  = 4'd5;
        in_DEC  = 4'd4;
        in_DONE = 1'b1;
        su = 7'h12;
        sd = 7'h19;
        tick();
        k = 0;
        checks++;
        if (out_VALID !== 1'b1) begin
            errors++;
            $display("FAIL valid_after_capture: vld=%b want 1", out_VALID);
        end
        checks++;
        if (out_AN !== 2'b11) begin
            errors++;
            $display("FAIL an_capture_cycle: an=%b want 11", out_AN);
        end
        // Changed inputs while in_DONE stays high must never be captured.
        in_UND = 4'd3;
        in_DEC = 4'd6;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (k == 24) in_DONE = 1'b0;
            checks++;
            if (out_AN !== exp_an(k)) begin
                errors++;
                $display("FAIL cap_an k=%0d: an=%b want %b", k, out_AN, exp_an(k));
            end
            checks++;
            if (out_SEG !== exp_seg(k)) begin
                errors++;
                $display("FAIL cap_seg k=%0d: seg=%h want %h", k, out_SEG, exp_seg(k));
            end
        end
    endtask

    task automatic test_midphase;
        while (k < 44) begin
            tick();
            checks++;
            if (out_AN !== exp_an(k) || out_SEG !== exp_seg(k)) begin
                errors++;
                $display("FAIL mid_pre k=%0d: an=%b seg=%h want %b %h", k, out_AN, out_SEG, exp_an(k), exp_seg(k));
            end
        end
        in_UND  = 4'd9;
        in_DEC  = 4'd4;
        in_DONE = 1'b1;
        while (k < 60) begin
            tick();
            checks++;
            if (out_AN !== exp_an(k) || out_SEG !== exp_seg(k)) begin
                errors++;
                $display("FAIL mid k=%0d: an=%b seg=%h want %b %h", k, out_AN, out_SEG, exp_an(k), exp_seg(k));
            end
            if (k == 45) su = 7'h10;
            if (k == 46) in_DONE = 1'b0;
        end
    endtask

    task automatic test_invalid;
        in_UND  = 4'hC;
        in_DEC  = 4'hF;
        in_DONE = 1'b1;
        while (k < 100) begin
            tick();
            checks++;
            if (out_AN !== exp_an(k) || out_SEG !== exp_seg(k)) begin
                errors++;
                $display("FAIL invalid k=%0d: an=%b seg=%h want %b %h", k, out_AN, out_SEG, exp_an(k), exp_seg(k));
            end
            if (k == 61) begin
                su = 7'h3F;
                sd = 7'h3F;
            end
            if (k == 62) in_DONE = 1'b0;
        end
    endtask

    task automatic test_leading_zero;
        in_UND  = 4'd7;
        in_DEC  = 4'd0;
        in_DONE = 1'b1;
        while (k < 140) begin
            tick();
            checks++;
            if (out_AN !== exp_an(k) || out_SEG !== exp_seg(k)) begin
                errors++;
                $display("FAIL lead_zero k=%0d: an=%b seg=%h want %b %h", k, out_AN, out_SEG, exp_an(k), exp_seg(k));
            end
            if (k == 101) begin
                su = 7'h78;
                sd = 7'h40;
`ifdef LEADING_ZERO_BLANK_EN
                dec_an = 2'b11;
`endif
            end
            if (k == 102) in_DONE = 1'b0;
        end
    endtask

    task automatic test_async_reset;
        while (((k - 1) % 20) != 14) tick();
        checks++;
        if (out_AN !== exp_an(k)) begin
            errors++;
            $display("FAIL pre_reset_an: an=%b want %b", out_AN, exp_an(k));
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out_SEG !== 7'h7F || out_AN !== 2'b11 || out_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_show: seg=%h an=%b vld=%b want 7f 11 0", out_SEG, out_AN, out_VALID);
        end
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (out_SEG !== 7'h7F || out_AN !== 2'b11 || out_VALID !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle_%0d: seg=%h an=%b vld=%b want 7f 11 0", i, out_SEG, out_AN, out_VALID);
            end
        end
    endtask

    initial begin
        su = 7'h7F;
        sd = 7'h7F;
        dec_an = 2'b01;
        test_reset();
        test_capture();
        test_midphase();
        test_invalid();
        test_leading_zero();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_display_mux.md
BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 Parameter: REFRESH_DIV, 16'd50000, number of clk cycles each digit is lit per phase (legal 2..65535).
REQ-002 Parameter: GUARD_CYC, 4'd4, number of clk cycles with both anodes off before each digit (legal 1..15).
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-low reset.
REQ-005 Port: in_UND  in  4  BCD units digit from the BCD converter.
REQ-006 Port: in_DEC  in  4  BCD tens digit from the BCD converter.
REQ-007 Port: in_DONE  in  1  converter done level, held high for several cycles per conversion.
REQ-008 Port: out_SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 Port: out_AN  out  2  anodes, active-low: bit0 = units, bit1 = tens.
REQ-010 Port: out_VALID  out  1  high once at least one result has been captured.

Function
REQ-011 Capture shall occur only on the rising edge of in_DONE, detected with a registered copy of in_DONE.
- in_UND and in_DEC are latched into the digit registers on the cycle the edge is detected.
- A held-high in_DONE shall not cause recapture.
REQ-012 out_VALID shall go high on the cycle after the first capture and stay high until reset.
REQ-013 FSM states: IDLE, GUARD_UND, SHOW_UND, GUARD_DEC, SHOW_DEC.
REQ-014 IDLE behaviour:
- out_AN = 2'b11 and out_SEG = 7'h7F.
- Exit to GUARD_UND on the cycle after the first capture.
REQ-015 GUARD_x states:
- out_AN = 2'b11 and out_SEG = 7'h7F.
- Last GUARD_CYC cycles, then advance to SHOW_x.
REQ-016 SHOW_UND state:
- out_AN = 2'b10 and out_SEG = encoding of the units register.
- Last REFRESH_DIV cycles, then advance to GUARD_DEC.
REQ-017 SHOW_DEC state:
- out_AN = 2'b01 and out_SEG = encoding of the tens register.
- Last REFRESH_DIV cycles, then advance to GUARD_UND (wrap-around).
REQ-018 A single 16-bit down counter shall time every phase.
- It is loaded with the phase length minus 1 on state entry.
- The state advances when the counter is 0.
- There is no off-by-one: one full cycle = 2*(GUARD_CYC+REFRESH_DIV) clocks.
REQ-019 Encoding (active-low gfedcba) shall be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-020 Non-BCD input codes (10..15) shall display a dash, 7'h3F.
REQ-021 A capture during a SHOW or GUARD state shall not restart the phase or the counter; the new value appears on the next cycle.
REQ-022 If capture and a phase change fall on the same cycle, both shall take effect: the new state shows the new digits.
REQ-023 out_SEG and out_AN shall be registered, so that there are no combinational glitches on the pins.
- Both change one cycle after the state or register update.

Reset
REQ-024 Reset values while rst = 0, applied immediately and independent of clk:
- state = IDLE, counter = 0, digit registers = 0, edge register = 0.
- out_SEG = 7'h7F, out_AN = 2'b11, out_VALID = 0.
REQ-025 A reset asserted mid-phase shall blank the display at once.
- After release, the block returns to IDLE and waits for a new in_DONE edge.
- Previously captured digits are lost.

Configuration
REQ-026 Macro LEADING_ZERO_BLANK_EN, when defined: in SHOW_DEC with a tens register of 0, out_SEG = 7'h7F and out_AN = 2'b11.
- Phase timing is unchanged.
REQ-027 LEADING_ZERO_BLANK_EN, when undefined: a tens digit of 0 shall display 7'h40 like any other digit.

Verification (REFRESH_DIV=8, GUARD_CYC=2 on the bench)
REQ-028 Check reset and idle:
- Stimulus: rst low, then high, with no in_DONE.
- Required response: out_AN = 11, out_SEG = 7F and out_VALID = 0 indefinitely.
REQ-029 Check capture and the first display:
- Stimulus: in_UND = 5, in_DEC = 4, in_DONE high for 25 cycles.
- Required response: out_VALID = 1; out_AN pattern 11x2, 10x8 (SEG = 12), 11x2, 01x8 (SEG = 19), repeating with a 20-cycle period.
- There shall be exactly one capture.
REQ-030 Check mid-phase update:
- Stimulus: during SHOW_UND, a new in_DONE edge with in_UND = 9.
- Required response: SEG = 10 on the next output cycle, and the phase end time is unchanged.
REQ-031 Check invalid input:
- Stimulus: in_UND = 4'hC, in_DEC = 4'hF.
- Required response: both digits show 3F.
REQ-032 Check leading zero:
- Stimulus: in_DEC = 0, in_UND = 7.
- Required response with LEADING_ZERO_BLANK_EN defined: tens phase AN = 11, SEG = 7F.
- Required response with the macro undefined: AN = 01, SEG = 40.
REQ-033 Check asynchronous reset mid-show:
- Stimulus: rst low between clock edges while in SHOW_DEC.
- Required response: outputs go to 7F / 11 / 0 before the next clk edge, and the block stays in IDLE after release.
